// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: register index,
// data word and the buffered long-latency result entry.
package rf_wb_arbiter_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 1 << REG_AW;

  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]   xdata_t;

  typedef struct packed {
    reg_idx_t rd;
    xdata_t   wd;
  } wb_entry_t;

  // One-hot mask of a destination register; x0 never appears in the mask.
  function automatic logic [NREGS-1:0] reg_mask(input reg_idx_t r);
    reg_mask = '0;
    if (r != '0) reg_mask[r] = 1'b1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding long-latency results until the register-file
// write port is free. Push and pop may happen in the same cycle.
module wb_fifo
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  wb_entry_t   mem_q [DEPTH];
  logic        push_ok, pop_ok;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only
  // ever read after it was written, so reset pointers alone make it empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between pipeline writeback and a
// buffered long-latency unit; tracks in-flight destinations for decode stall.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_LIM = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_wd,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [REG_AW-1:0] mdu_rd,
  input  logic [XLEN-1:0]   mdu_wd,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic [REG_AW-1:0] dec_rd,
  output logic              dec_stall,
  output logic              wb_stall,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_a3,
  output logic [XLEN-1:0]   rf_wd,
  output logic [NREGS-1:0]  busy
);

  localparam int              CW    = $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0]   LIM_C = CW'(STARVE_LIM);

  wb_entry_t        fifo_head;
  logic             fifo_full, fifo_empty;
  logic             fifo_push, fifo_pop;
  logic             wb_fire;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NREGS-1:0] busy_q, busy_d;

  // Writes to x0 are dropped so the port is free for a buffered result.
  assign wb_fire   = wb_we && (wb_rd != '0);
  assign fifo_pop  = !wb_fire && !fifo_empty;
  assign fifo_push = mdu_valid && !fifo_full && (mdu_rd != '0);
  assign mdu_ready = !fifo_full;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data ('{rd: mdu_rd, wd: mdu_wd}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // NOTE: every output of this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    rf_we = 1'b0;
    rf_a3 = wb_rd;
    rf_wd = wb_wd;
    if (wb_fire) begin
      rf_we = rst_n;
    end else if (!fifo_empty) begin
      rf_we = rst_n;
      rf_a3 = fifo_head.rd;
      rf_wd = fifo_head.wd;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (fifo_empty || fifo_pop) cnt_d = '0;
    else if (cnt_q != LIM_C)    cnt_d = cnt_q + 1'b1;
  end

  assign wb_stall = (cnt_q == LIM_C);

  // Clear is applied before set so a same-cycle reissue keeps the bit.
  always_comb begin
    busy_d = busy_q;
    if (fifo_pop)  busy_d = busy_d & ~reg_mask(fifo_head.rd);
    if (iss_valid) busy_d = busy_d | reg_mask(iss_rd);
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      busy_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign dec_stall = busy_q[dec_rs1] | busy_q[dec_rs2] | busy_q[dec_rd];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed table, multi-cycle corner
// sequences and randomized traffic against a queue-based reference model.
module tb_rf_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int LIM   = 3;

  logic        clk;
  logic        rst_n;
  logic        wb_we, mdu_valid, iss_valid;
  logic [4:0]  wb_rd, mdu_rd, iss_rd, dec_rs1, dec_rs2, dec_rd;
  logic [31:0] wb_wd, mdu_wd;
  logic        mdu_ready, dec_stall, wb_stall, rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd, busy;

  rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_wd(mdu_wd),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_stall(dec_stall), .wb_stall(wb_stall),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: pending results in arrival order, pending-register set,
  // and the number of consecutive cycles the oldest result has waited.
  typedef struct { logic [4:0] rd; logic [31:0] wd; } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_busy;
  int          m_wait;

  // Outputs as sampled in the most recent cycle, before its clock edge.
  logic        l_rf_we, l_ready, l_dec, l_wb_stall;
  logic [4:0]  l_a3;
  logic [31:0] l_wd, l_busy;

  task automatic idle();
    wb_we = 1'b0; wb_rd = '0; wb_wd = '0;
    mdu_valid = 1'b0; mdu_rd = '0; mdu_wd = '0;
    iss_valid = 1'b0; iss_rd = '0;
    dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
  endtask

  function automatic logic pending(input logic [4:0] r);
    return (r != 5'd0) && m_busy[r];
  endfunction

  // Check one cycle against the model, take the clock edge, update the model.
  task automatic cycle();
    logic        wb_ok, e_we, popped;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    #1;
    wb_ok = wb_we && (wb_rd != 5'd0);
    e_we  = wb_ok || (m_q.size() > 0);
    e_a3  = wb_ok ? wb_rd : (m_q.size() > 0 ? m_q[0].rd : 5'd0);
    e_wd  = wb_ok ? wb_wd : (m_q.size() > 0 ? m_q[0].wd : 32'd0);
    check("rf_we", rf_we, e_we);
    if (e_we) begin
      check("rf_a3", rf_a3, e_a3);
      check("rf_wd", rf_wd, e_wd);
    end
    check("mdu_ready", mdu_ready, m_q.size() < DEPTH);
    check("wb_stall", wb_stall, m_wait >= LIM);
    check("dec_stall", dec_stall, pending(dec_rs1) || pending(dec_rs2) || pending(dec_rd));
    check("busy", busy, m_busy);
    l_rf_we = rf_we; l_a3 = rf_a3; l_wd = rf_wd; l_ready = mdu_ready;
    l_dec = dec_stall; l_busy = busy; l_wb_stall = wb_stall;
    @(posedge clk);
    popped = !wb_ok && (m_q.size() > 0);
    if (m_q.size() == 0 || popped) m_wait = 0;
    else if (m_wait < LIM)         m_wait++;
    if (popped) begin
      m_busy[m_q[0].rd] = 1'b0;
      void'(m_q.pop_front());
    end
    if (mdu_valid && l_ready && mdu_rd != 5'd0) m_q.push_back('{rd: mdu_rd, wd: mdu_wd});
    if (iss_valid && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
    #1;
  endtask

  // Assert reset with whatever inputs are currently driven, check the
  // immediate effect, then release away from the clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    m_q.delete(); m_busy = '0; m_wait = 0;
    #1;
    check("rst_rf_we", rf_we, 1'b0);
    check("rst_busy", busy, 32'd0);
    check("rst_mdu_ready", mdu_ready, 1'b1);
    check("rst_wb_stall", wb_stall, 1'b0);
    check("rst_dec_stall", dec_stall, 1'b0);
    idle();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic wb_we; logic [4:0] wb_rd; logic [31:0] wb_wd;
    logic mdu_v; logic [4:0] mdu_rd; logic [31:0] mdu_wd;
    logic iss_v; logic [4:0] iss_rd; logic [4:0] rs1;
    logic e_we; logic [4:0] e_a3; logic [31:0] e_wd;
    logic e_ready; logic e_dec; logic [31:0] e_busy;
  } vec_t;

  localparam logic [31:0] B0 = 32'h0;
  localparam logic [31:0] B5 = 32'h20;
  localparam logic [31:0] B7 = 32'h80;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[$];
    int         written_at, stall_cycles, wb_sent, k12_acc, k10_pop, stale;
    logic [4:0] order[$];
    logic [4:0] pend[$];
    int         rr;

    idle();
    rst_n = 1'b0;
    @(posedge clk);
    wb_we = 1'b1; wb_rd = 5'd3; wb_wd = 32'h1234; dec_rs1 = 5'd5;
    do_reset();

    // ---- directed table: single op, x0 boundaries, set-wins, passthrough
    tbl.push_back('{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd5, 1'b0,5'd0,32'h0, 1'b1,1'b0,B0});
    tbl.push_back('{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,5'd5, 5'd5, 1'b0,5'd0,32'h0, 1'b1,1'b0,B0});
    tbl.push_back('{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd5, 1'b0,5'd0,32'h0, 1'b1,1'b1,B5});
    tbl.push_back('{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd5, 1'b0,5'd0,32'h0, 1'b1,1'b1,B5});
    tbl.push_back('{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd5, 1'b0,5'd0,32'h0, 1'b1,1'b1,B5});
    tbl.push_back('{1'b0,5'd0,32'h0, 1'b1,5'd5,32'hDEADBEEF, 1'b0,5'd0, 5'd5, 1'b0,5'd0,32'h0, 1'b1,1'b1,B5});
    tbl.push_back('{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd5, 1'b1,5'd5,32'hDEADBEEF, 1'b1,1'b1,B5});
    tbl.push_back('{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd5, 1'b0,5'd0,32'h0, 1'b1,1'b0,B0});
    tbl.push_back('{1'b0,5'd0,32'h0, 1'b1,5'd0,32'h123, 1'b1,5'd0, 5'd0, 1'b0,5'd0,32'h0, 1'b1,1'b0,B0});
    tbl.push_back('{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd0, 1'b0,5'd0,32'h0, 1'b1,1'b0,B0});
    tbl.push_back('{1'b1,5'd0,32'h55, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd0, 1'b0,5'd0,32'h0, 1'b1,1'b0,B0});
    tbl.push_back('{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,5'd7, 5'd7, 1'b0,5'd0,32'h0, 1'b1,1'b0,B0});
    tbl.push_back('{1'b0,5'd0,32'h0, 1'b1,5'd7,32'h77, 1'b0,5'd0, 5'd7, 1'b0,5'd0,32'h0, 1'b1,1'b1,B7});
    tbl.push_back('{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,5'd7, 5'd7, 1'b1,5'd7,32'h77, 1'b1,1'b1,B7});
    tbl.push_back('{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd7, 1'b0,5'd0,32'h0, 1'b1,1'b1,B7});
    tbl.push_back('{1'b0,5'd0,32'h0, 1'b1,5'd7,32'h78, 1'b0,5'd0, 5'd7, 1'b0,5'd0,32'h0, 1'b1,1'b1,B7});
    tbl.push_back('{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd7, 1'b1,5'd7,32'h78, 1'b1,1'b1,B7});
    tbl.push_back('{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd7, 1'b0,5'd0,32'h0, 1'b1,1'b0,B0});
    tbl.push_back('{1'b1,5'd3,32'h33, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd0, 1'b1,5'd3,32'h33, 1'b1,1'b0,B0});

    foreach (tbl[i]) begin
      idle();
      wb_we = tbl[i].wb_we; wb_rd = tbl[i].wb_rd; wb_wd = tbl[i].wb_wd;
      mdu_valid = tbl[i].mdu_v; mdu_rd = tbl[i].mdu_rd; mdu_wd = tbl[i].mdu_wd;
      iss_valid = tbl[i].iss_v; iss_rd = tbl[i].iss_rd; dec_rs1 = tbl[i].rs1;
      cycle();
      check($sformatf("tbl[%0d].rf_we", i), l_rf_we, tbl[i].e_we);
      if (tbl[i].e_we) begin
        check($sformatf("tbl[%0d].rf_a3", i), l_a3, tbl[i].e_a3);
        check($sformatf("tbl[%0d].rf_wd", i), l_wd, tbl[i].e_wd);
      end
      check($sformatf("tbl[%0d].mdu_ready", i), l_ready, tbl[i].e_ready);
      check($sformatf("tbl[%0d].dec_stall", i), l_dec, tbl[i].e_dec);
      check($sformatf("tbl[%0d].busy", i), l_busy, tbl[i].e_busy);
    end

    // ---- contention: wb every cycle to x1..x8, MDU delivers x9
    idle(); iss_valid = 1'b1; iss_rd = 5'd9; cycle();
    written_at = -1; stall_cycles = 0; wb_sent = 0; rr = 0;
    for (int k = 0; k < 14; k++) begin
      idle();
      wb_we = !wb_stall; wb_rd = 5'(1 + rr % 8); wb_wd = $urandom;
      if (wb_we) begin rr++; wb_sent++; end
      if (k == 0) begin mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_wd = 32'h0900D009; end
      cycle();
      if (l_rf_we && l_a3 == 5'd9 && written_at < 0) written_at = k;
      if (l_wb_stall) stall_cycles++;
    end
    checks++;
    if (written_at < 1 || written_at > LIM + 2) begin
      errors++;
      $display("FAIL x9_latency: written at cycle %0d, required 1..%0d", written_at, LIM + 2);
    end
    check("wb_stall_pulse_len", stall_cycles, 1);
    check("wb_writes_presented", wb_sent, 13);
    idle(); repeat (2) cycle();

    // ---- full FIFO: x10,x11,x12 back-to-back during continuous wb
    pend = '{5'd10, 5'd11, 5'd12};
    k12_acc = -1; k10_pop = -1; rr = 0;
    for (int k = 0; k < 30; k++) begin
      idle();
      wb_we = !wb_stall; wb_rd = 5'(1 + rr % 8); wb_wd = $urandom; rr++;
      if (pend.size() > 0) begin
        mdu_valid = 1'b1; mdu_rd = pend[0]; mdu_wd = 32'h1000 + 32'(pend[0]);
      end
      cycle();
      if (k == 2) check("third_ready_low", l_ready, 1'b0);
      if (mdu_valid && l_ready) begin
        if (mdu_rd == 5'd12) k12_acc = k;
        void'(pend.pop_front());
      end
      if (l_rf_we && l_a3 >= 5'd10 && l_a3 <= 5'd12) begin
        if (l_a3 == 5'd10) k10_pop = k;
        order.push_back(l_a3);
      end
    end
    check("x12_accept_after_first_pop", k12_acc, k10_pop + 1);
    check("order_len", order.size(), 3);
    foreach (order[i]) check($sformatf("order[%0d]", i), order[i], 32'(10 + i));
    idle(); repeat (2) cycle();

    // ---- reset with two results buffered
    for (int k = 0; k < 2; k++) begin
      idle();
      wb_we = 1'b1; wb_rd = 5'd1; wb_wd = 32'hA;
      iss_valid = 1'b1; iss_rd = 5'(20 + k);
      mdu_valid = 1'b1; mdu_rd = 5'(20 + k); mdu_wd = 32'hB0 + 32'(k);
      cycle();
    end
    check("prefill_mdu_ready", mdu_ready, 1'b0);
    idle(); wb_we = 1'b1; wb_rd = 5'd2; dec_rs1 = 5'd20; dec_rs2 = 5'd21;
    do_reset();
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      idle(); cycle();
      if (l_rf_we) stale++;
    end
    check("no_stale_write", stale, 0);

    // ---- randomized traffic against the model, with one reset mid-run
    for (int k = 0; k < 400; k++) begin
      if (k == 200) do_reset();
      wb_we = ($urandom_range(0, 3) != 0);
      if (wb_stall && $urandom_range(0, 3) != 0) wb_we = 1'b0;
      wb_rd = 5'($urandom_range(0, 31)); wb_wd = $urandom;
      mdu_valid = $urandom_range(0, 1) == 1;
      mdu_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mdu_wd = $urandom;
      iss_valid = $urandom_range(0, 1) == 1;
      iss_rd = 5'($urandom_range(0, 31));
      dec_rs1 = 5'($urandom_range(0, 31));
      dec_rs2 = 5'($urandom_range(0, 31));
      dec_rd  = 5'($urandom_range(0, 31));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
